// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through or runs one load/store on the data bus.
// Latency: 1 cycle for pass-through and misaligned results; 1 cycle after ack (or timeout) for bus accesses.
// Backpressure: ready_o drops while a bus access is outstanding; upstream holds valid_i until accepted.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    input  logic [1:0]  wb_sel_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        valid_o,
    output logic [4:0]  rd_o,
    output logic        reg_write_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    // Context of the outstanding access, captured at accept.
    logic        store_q, store_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        sel_mem_q, sel_mem_d;
    logic [4:0]  rd_pend_q, rd_pend_d;
    logic        rw_pend_q, rw_pend_d;
    logic [31:0] pass_q, pass_d;
    // Registered outputs.
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        valid_q, valid_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic [31:0] wb_q, wb_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic        accept;
    logic        is_mem;
    logic        misaligned;
    logic [31:0] pass_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign ready_o = (state_q == IDLE) && !rst;

    // Next-state, access setup, load extraction and completion logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        store_d   = store_q;
        f3_d      = f3_q;
        off_d     = off_q;
        sel_mem_d = sel_mem_q;
        rd_pend_d = rd_pend_q;
        rw_pend_d = rw_pend_q;
        pass_d    = pass_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        valid_d   = 1'b0;
        rd_d      = rd_q;
        rw_d      = rw_q;
        wb_d      = wb_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;

        accept   = valid_i && ready_o;
        is_mem   = mem_read_i || mem_write_i;
        pass_val = (wb_sel_i == 2'b10) ? pc_plus4_i : alu_result_i;

        // funct3[1:0]: 00 byte, 01 halfword, otherwise word.
        case (funct3_i[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = alu_result_i[0];
            default: misaligned = |alu_result_i[1:0];
        endcase

        case (off_q)
            2'b00:   ld_byte = dmem_rdata_i[7:0];
            2'b01:   ld_byte = dmem_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (f3_q[1:0])
            2'b00:   ld_val = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
            2'b01:   ld_val = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
            default: ld_val = dmem_rdata_i;
        endcase

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_pend_d = rd_i;
                    rw_pend_d = reg_write_i && (rd_i != 5'd0);
                    pass_d    = pass_val;
                    if (!is_mem) begin
                        valid_d = 1'b1;
                        rd_d    = rd_i;
                        rw_d    = reg_write_i && (rd_i != 5'd0);
                        wb_d    = pass_val;
                    end else if (misaligned) begin
                        valid_d = 1'b1;
                        mis_d   = 1'b1;
                        rd_d    = rd_i;
                        rw_d    = 1'b0;
                        wb_d    = pass_val;
                    end else begin
                        state_d   = WAIT;
                        cnt_d     = 8'd0;
                        store_d   = mem_write_i;
                        f3_d      = funct3_i;
                        off_d     = alu_result_i[1:0];
                        sel_mem_d = (wb_sel_i == 2'b01);
                        req_d     = 1'b1;
                        we_d      = mem_write_i;
                        addr_d    = {alu_result_i[31:2], 2'b00};
                        if (mem_write_i) begin
                            case (funct3_i[1:0])
                                2'b00: begin
                                    be_d    = 4'b0001 << alu_result_i[1:0];
                                    wdata_d = {4{rs2_i[7:0]}};
                                end
                                2'b01: begin
                                    be_d    = alu_result_i[1] ? 4'b1100 : 4'b0011;
                                    wdata_d = {2{rs2_i[15:0]}};
                                end
                                default: begin
                                    be_d    = 4'b1111;
                                    wdata_d = rs2_i;
                                end
                            endcase
                        end else begin
                            be_d    = 4'b0000;
                            wdata_d = 32'd0;
                        end
                    end
                end
            end
            WAIT: begin
                // Ack takes priority over the timeout in the same cycle.
                if (dmem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    rd_d    = rd_pend_q;
                    rw_d    = rw_pend_q && !store_q;
                    wb_d    = sel_mem_q ? ld_val : pass_q;
                end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    berr_d  = 1'b1;
                    rd_d    = rd_pend_q;
                    rw_d    = 1'b0;
                    wb_d    = pass_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            store_q   <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            sel_mem_q <= 1'b0;
            rd_pend_q <= 5'd0;
            rw_pend_q <= 1'b0;
            pass_q    <= 32'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            valid_q   <= 1'b0;
            rd_q      <= 5'd0;
            rw_q      <= 1'b0;
            wb_q      <= 32'd0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            store_q   <= store_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            sel_mem_q <= sel_mem_d;
            rd_pend_q <= rd_pend_d;
            rw_pend_q <= rw_pend_d;
            pass_q    <= pass_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            rw_q      <= rw_d;
            wb_q      <= wb_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign valid_o      = valid_q;
    assign rd_o         = rd_q;
    assign reg_write_o  = rw_q;
    assign wb_data_o    = wb_q;
    assign misalign_o   = mis_q;
    assign bus_err_o    = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected completions, a monitor pops on valid_o.
// Bus-side signals are checked directly by the stimulus process.
// All waits are fixed cycle counts or bounded loops.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] alu_result_i;
    logic [31:0] rs2_i;
    logic [31:0] pc_plus4_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        reg_write_i;
    logic [1:0]  wb_sel_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;
    logic        bus_err_o;

    mem_stage #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .alu_result_i(alu_result_i), .rs2_i(rs2_i), .pc_plus4_i(pc_plus4_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
        .rd_i(rd_i), .reg_write_i(reg_write_i), .wb_sel_i(wb_sel_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .valid_o(valid_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    typedef struct packed {
        logic        mis;
        logic        berr;
        logic [4:0]  rd;
        logic        rw;
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   req_cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic mis, input logic berr, input logic [4:0] rd,
                                input logic rw, input logic cd, input logic [31:0] dat);
        exp_t e;
        e.mis = mis; e.berr = berr; e.rd = rd; e.rw = rw; e.chk_dat = cd; e.dat = dat;
        return e;
    endfunction

    // Drive one transaction and hold it for exactly one accepting edge; returns #1 after that edge.
    task automatic send(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] pc4,
                        input logic [4:0] rd, input logic rw, input logic [1:0] sel, input exp_t e);
        valid_i = 1'b1; mem_read_i = mr; mem_write_i = mw; funct3_i = f3;
        alu_result_i = addr; rs2_i = rs2; pc_plus4_i = pc4;
        rd_i = rd; reg_write_i = rw; wb_sel_i = sel;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    endtask

    // Called in the first WAIT cycle: let n cycles pass without ack, then ack one cycle.
    task automatic ack_after(input int n, input logic [31:0] rdata);
        repeat (n) @(posedge clk);
        #1;
        dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
        @(posedge clk);
        #1;
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'hx;
        chk("req_dropped_after_ack", {31'd0, dmem_req_o}, 32'd0);
    endtask

    // Monitor: every valid_o pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rd=%0d wb=0x%08h expected no completion", rd_o, wb_data_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("misalign_o", {31'd0, misalign_o}, {31'd0, e.mis});
                chk("bus_err_o", {31'd0, bus_err_o}, {31'd0, e.berr});
                chk("rd_o", {27'd0, rd_o}, {27'd0, e.rd});
                chk("reg_write_o", {31'd0, reg_write_o}, {31'd0, e.rw});
                if (e.chk_dat) chk("wb_data_o", wb_data_o, e.dat);
            end
        end
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; alu_result_i = '0; rs2_i = '0; pc_plus4_i = '0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = '0; rd_i = '0;
        reg_write_i = 1'b0; wb_sel_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, ready_o}, 32'd1);

        // ALU pass-through, pc+4 link, rd=0 suppression, wb_sel=11.
        send(0, 0, 3'b000, 32'h1234, 0, 32'h0, 5'd5, 1, 2'b00, mk(0, 0, 5'd5, 1, 1, 32'h1234));
        send(0, 0, 3'b000, 32'h5555, 0, 32'h44, 5'd1, 1, 2'b10, mk(0, 0, 5'd1, 1, 1, 32'h44));
        send(0, 0, 3'b000, 32'h7777, 0, 32'h0, 5'd0, 1, 2'b00, mk(0, 0, 5'd0, 0, 1, 32'h7777));
        send(0, 0, 3'b000, 32'h9999, 0, 32'h8, 5'd2, 0, 2'b11, mk(0, 0, 5'd2, 0, 1, 32'h9999));

        // Ack while idle must not produce a completion.
        dmem_ack_i = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack_i = 1'b0;
        chk("idle_ack_no_req", {31'd0, dmem_req_o}, 32'd0);

        // LB / LBU at 0x1003, ack in the third WAIT cycle.
        send(1, 0, 3'b000, 32'h1003, 0, 0, 5'd3, 1, 2'b01, mk(0, 0, 5'd3, 1, 1, 32'hFFFFFF80));
        chk("lb_req", {31'd0, dmem_req_o}, 32'd1);
        chk("lb_addr", dmem_addr_o, 32'h1000);
        chk("lb_be", {28'd0, dmem_be_o}, 32'd0);
        chk("lb_we", {31'd0, dmem_we_o}, 32'd0);
        chk("lb_ready_busy", {31'd0, ready_o}, 32'd0);
        ack_after(2, 32'h80FFFFFF);
        send(1, 0, 3'b100, 32'h1003, 0, 0, 5'd3, 1, 2'b01, mk(0, 0, 5'd3, 1, 1, 32'h00000080));
        ack_after(2, 32'h80FFFFFF);

        // Halfword and word loads.
        send(1, 0, 3'b001, 32'h1002, 0, 0, 5'd10, 1, 2'b01, mk(0, 0, 5'd10, 1, 1, 32'hFFFF80FF));
        ack_after(0, 32'h80FFFFFF);
        send(1, 0, 3'b101, 32'h1000, 0, 0, 5'd11, 1, 2'b01, mk(0, 0, 5'd11, 1, 1, 32'h00008765));
        ack_after(1, 32'h12348765);
        send(1, 0, 3'b010, 32'h1004, 0, 0, 5'd12, 1, 2'b01, mk(0, 0, 5'd12, 1, 1, 32'hDEADBEEF));
        chk("lw_addr", dmem_addr_o, 32'h1004);
        ack_after(0, 32'hDEADBEEF);

        // Stores: SH upper half, SB with read+write both set, SW.
        send(0, 1, 3'b001, 32'h2002, 32'hAAAA5555, 0, 5'd7, 1, 2'b00, mk(0, 0, 5'd7, 0, 0, 32'h0));
        chk("sh_we", {31'd0, dmem_we_o}, 32'd1);
        chk("sh_addr", dmem_addr_o, 32'h2000);
        chk("sh_be", {28'd0, dmem_be_o}, 32'hC);
        chk("sh_wdata", dmem_wdata_o, 32'h55555555);
        ack_after(1, 32'h0);
        send(1, 1, 3'b000, 32'h2001, 32'h000000A5, 0, 5'd8, 1, 2'b01, mk(0, 0, 5'd8, 0, 0, 32'h0));
        chk("sb_we", {31'd0, dmem_we_o}, 32'd1);
        chk("sb_be", {28'd0, dmem_be_o}, 32'h2);
        chk("sb_wdata", dmem_wdata_o, 32'hA5A5A5A5);
        ack_after(0, 32'h0);
        send(0, 1, 3'b010, 32'h2004, 32'h01234567, 0, 5'd9, 1, 2'b00, mk(0, 0, 5'd9, 0, 0, 32'h0));
        chk("sw_be", {28'd0, dmem_be_o}, 32'hF);
        chk("sw_wdata", dmem_wdata_o, 32'h01234567);
        ack_after(0, 32'h0);

        // Misaligned LW and SH: no bus request.
        send(1, 0, 3'b010, 32'h0006, 0, 0, 5'd4, 1, 2'b01, mk(1, 0, 5'd4, 0, 0, 32'h0));
        chk("mis_lw_no_req", {31'd0, dmem_req_o}, 32'd0);
        send(0, 1, 3'b001, 32'h2003, 0, 0, 5'd6, 1, 2'b00, mk(1, 0, 5'd6, 0, 0, 32'h0));
        chk("mis_sh_no_req", {31'd0, dmem_req_o}, 32'd0);

        // LW without ack: request held MAX_WAIT cycles, then bus error.
        send(1, 0, 3'b010, 32'h3000, 0, 0, 5'd13, 1, 2'b01, mk(0, 1, 5'd13, 0, 0, 32'h0));
        req_cycles = 0;
        while (dmem_req_o && req_cycles < 40) begin
            req_cycles++;
            @(posedge clk);
            #1;
        end
        chk("timeout_req_cycles", req_cycles, 32'd15);

        // Ack in the 15th WAIT cycle wins over the timeout.
        send(1, 0, 3'b010, 32'h1008, 0, 0, 5'd9, 1, 2'b01, mk(0, 0, 5'd9, 1, 1, 32'h0BADF00D));
        ack_after(14, 32'h0BADF00D);

        // Reset in the third WAIT cycle, late ack afterwards.
        sb_q.push_back(mk(0, 0, 5'd0, 0, 0, 32'h0));
        void'(sb_q.pop_back());
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_result_i = 32'h3000;
        rd_i = 5'd14; reg_write_i = 1'b1; wb_sel_i = 2'b01;
        @(posedge clk);
        #1;
        valid_i = 1'b0; mem_read_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("ready_during_rst", {31'd0, ready_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12345678;
        chk("rst_wait_req_dropped", {31'd0, dmem_req_o}, 32'd0);
        #1;
        chk("ready_after_wait_rst", {31'd0, ready_o}, 32'd1);
        @(posedge clk);
        #1;
        dmem_ack_i = 1'b0;
        chk("late_ack_no_req", {31'd0, dmem_req_o}, 32'd0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MAX_WAIT, default 15, number of WAIT cycles without dmem_ack_i before a bus-error abort (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 valid_i  in  1  EX result valid; consumed only when ready_o=1.
REQ-005 ready_o  out  1  stage can accept; 1 iff state=IDLE and rst=0.
REQ-006 alu_result_i  in  32  effective address, or pass-through result.
REQ-007 rs2_i  in  32  store data.
REQ-008 pc_plus4_i  in  32  link value.
REQ-009 mem_read_i / mem_write_i  in  1 each  load / store request.
REQ-010 funct3_i  in  3  size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 rd_i  in  5; reg_write_i  in  1; wb_sel_i  in  2 (00 alu, 01 mem, 10 pc+4, 11 alu).
REQ-012 dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  32; dmem_wdata_o  out  32; dmem_be_o  out  4.
REQ-013 dmem_ack_i  in  1; dmem_rdata_i  in  32 (valid in the ack cycle).
REQ-014 valid_o  out  1; rd_o  out  5; reg_write_o  out  1; wb_data_o  out  32; misalign_o  out  1; bus_err_o  out  1.

Function
REQ-015 FSM states IDLE, WAIT; all outputs except ready_o are registered.
REQ-016 Accept = valid_i & ready_o; with mem_read_i=mem_write_i=0: next cycle valid_o=1, wb_data_o per wb_sel_i (alu_result_i or pc_plus4_i); latency 1; stay IDLE.
REQ-017 Both mem_read_i and mem_write_i set: treated as store.
REQ-018 Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0): no bus request; next cycle valid_o=1, misalign_o=1, reg_write_o=0; stay IDLE.
REQ-019 Aligned access: next cycle enter WAIT with dmem_req_o=1, dmem_addr_o={addr[31:2],2'b00}, dmem_we_o=store; request signals held stable until ack or abort.
REQ-020 Store lanes: SB be=0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=0011 (addr[1]=0) or 1100, wdata={2{rs2[15:0]}}; SW be=1111, wdata=rs2; loads drive be=0000.
REQ-021 dmem_ack_i sampled only in WAIT, including the first WAIT cycle; on ack: dmem_req_o=0 next cycle, valid_o=1 next cycle, return IDLE.
REQ-022 Load data: select byte/halfword lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged; wb_data_o = extracted value when wb_sel=01.
REQ-023 Stores complete with reg_write_o=0; any result with rd=0 has reg_write_o=0; otherwise reg_write_o=reg_write_i captured at accept.
REQ-024 Wait counter cleared on WAIT entry, +1 per WAIT cycle without ack; when it equals MAX_WAIT without ack: drop dmem_req_o, valid_o=1, bus_err_o=1, reg_write_o=0, return IDLE.
REQ-025 Ack in the same cycle the counter reaches MAX_WAIT: ack wins, normal completion.
REQ-026 valid_o, misalign_o, bus_err_o are single-cycle pulses; wb_data_o/rd_o hold until next completion.
REQ-027 dmem_ack_i in IDLE ignored; valid_i while ready_o=0 ignored (upstream holds).

Reset
REQ-028 rst=1 at clock edge: state IDLE, counter 0, all registered outputs 0 (dmem_req_o, valid_o, wb_data_o, rd_o, reg_write_o, misalign_o, bus_err_o, dmem_* buses).
REQ-029 Reset during WAIT aborts the access: dmem_req_o=0 after that edge, no valid_o pulse, late ack ignored.

Verification
REQ-030 ALU pass-through: alu_result_i=0x1234, wb_sel=00, rd=5, reg_write=1 -> next cycle valid_o=1, wb_data_o=0x1234, rd_o=5, reg_write_o=1.
REQ-031 LB addr=0x1003, ack after 2 WAIT cycles, rdata=0x80FFFFFF -> dmem_addr_o=0x1000, be=0000, wb_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr=0x2002, rs2=0xAAAA5555 -> dmem_we_o=1, be=1100, wdata=0x55555555, completion reg_write_o=0.
REQ-033 LW addr=0x0006 -> no dmem_req_o, next cycle valid_o=1, misalign_o=1, reg_write_o=0.
REQ-034 LW, no ack, MAX_WAIT=15 -> dmem_req_o high 15 cycles then dropped, bus_err_o pulse; ack arriving exactly at count 15 -> normal completion instead.
REQ-035 rst asserted in 3rd WAIT cycle, ack next cycle -> dmem_req_o=0, no valid_o, ready_o=1 the cycle after reset deasserts.
